motor_signal_stream: RTL and testbench
======================================

Name: motor_signal_stream

Overview:
- Rover-side drive controller. Accepts a 12-bit motion command (turn amount, forward distance) and generates servo-style pulse streams on two continuous-rotation wheel motors.
- Executes the turn-in-place first, then the straight move, then stops.
- Sits between the rover's command receiver/decoder and the left/right motor pins.

Parameters:
- FRAME_CYCLES, 2_000_000, servo frame period in clocks (20 ms at 100 MHz).
- PULSE_FWD_CYCLES, 200_000, high time for the "fwd" pulse (2.0 ms).
- PULSE_REV_CYCLES, 100_000, high time for the "rev" pulse (1.0 ms).
- TURN_FRAMES, 5, frames driven per unit of turn amount.
- MOVE_FRAMES, 10, frames driven per unit of distance.
- Constraint: 0 < PULSE_REV_CYCLES, PULSE_FWD_CYCLES < FRAME_CYCLES.

Ports:
- clock, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- command_ready, input, 1, a 0→1 transition offers a new command.
- command, input, 12, [11:7] turn amount A (0..31), [6:0] distance D (0..127).
- motor_l, output, 1, left wheel servo pulse stream (registered).
- motor_r, output, 1, right wheel servo pulse stream (registered).

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE; motor_l=motor_r=0.
  - All counters=0; command_ready history register=0.
- Acceptance:
  - A command is accepted on a rising edge where command_ready=1, the history register=0, and state=IDLE. A, D and command are latched at that edge.
  - Offers while TURN or MOVE are ignored and never queued.
  - command_ready held high is not re-accepted; it must return low first.
  - command_ready already high when reset releases counts as a rising edge.
- State after acceptance:
  - A≠0 → TURN.
  - A=0, D≠0 → MOVE.
  - A=0, D=0 → stay IDLE; outputs never pulse.
- Frame generator:
  - The frame counter restarts at 0 on entry to TURN or MOVE.
  - Within a frame, a motor output is 1 while counter < its pulse width, else 0.
  - Outputs are registered: the first high cycle is the clock edge after acceptance.
- TURN (clockwise rotate in place):
  - motor_l uses PULSE_FWD_CYCLES.
  - motor_r uses PULSE_FWD_CYCLES (right motor is mirror-mounted, so this drives that wheel backward).
  - Lasts exactly A*TURN_FRAMES full frames.
  - Then → MOVE if D≠0, else → IDLE, at the frame boundary.
- MOVE (straight forward):
  - motor_l uses PULSE_FWD_CYCLES; motor_r uses PULSE_REV_CYCLES.
  - Lasts exactly D*MOVE_FRAMES full frames, then → IDLE.
- TURN→MOVE handoff:
  - Seamless: the frame counter continues from 0, with no gap cycle.
- IDLE: both outputs held 0 (motors unpowered/stopped).
- Frame counting:
  - Frame/duration counters are wide enough for 31*TURN_FRAMES and 127*MOVE_FRAMES with no wrap.
  - Duration is counted in completed frames.
- Reset mid-operation: outputs go low immediately (asynchronous); the latched command is discarded.
- A change on command while not accepting has no effect.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, TURN, MOVE);
  - field positions of command (ANGLE_MSB=11, ANGLE_LSB=7, DIST_MSB=6, DIST_LSB=0);
  - default timing constants.
- One natural sub-module: servo_pulse_gen.
  - Inputs: frame counter/restart, enable, pulse-width select.
  - Output: one motor pin.
  - Instantiated twice (left/right).
- Sequencing FSM and duration counter stay in the top level.

Test Plan (bench parameters: FRAME_CYCLES=100, PULSE_FWD_CYCLES=20, PULSE_REV_CYCLES=10, TURN_FRAMES=2, MOVE_FRAMES=1; 10 ns clock):
- Reset: assert reset=0 mid-run → motor_l=motor_r=0 immediately; stay 0 in IDLE with command_ready=0.
- command=12'h104 (A=2, D=4), command_ready 0→1 → 4 frames (400 cycles) with both outputs 20-cycle pulses, then 4 frames with motor_l 20-cycle and motor_r 10-cycle pulses, then both 0. Total 800 cycles; first high edge one cycle after acceptance.
- command_ready held high after completion → no second run; drop low then raise → command re-executes.
- command=12'h004 (A=0, D=4) → skip TURN; 4 frames of MOVE pattern, then idle. command=12'h100 (A=2, D=0) → 4 TURN frames only.
- command=12'h000 with a ready pulse → outputs never go high.
- New ready edge with command=12'h081 during TURN → ignored; the original sequence length is unchanged. Reset asserted during MOVE → outputs 0, FSM IDLE, next command accepted normally.

Source files
------------

// File: rtl/motor_signal_stream_pkg.sv
// Shared types and constants for the rover drive controller.
// Command field layout, sequencer states and default servo timing.
package motor_signal_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    MOVE = 2'd2
  } state_e;

  localparam int ANGLE_MSB = 11;
  localparam int ANGLE_LSB = 7;
  localparam int DIST_MSB  = 6;
  localparam int DIST_LSB  = 0;

  localparam int DEF_FRAME_CYCLES     = 2_000_000;
  localparam int DEF_PULSE_FWD_CYCLES = 200_000;
  localparam int DEF_PULSE_REV_CYCLES = 100_000;
  localparam int DEF_TURN_FRAMES      = 5;
  localparam int DEF_MOVE_FRAMES      = 10;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/motor_signal_stream_pulse_gen.sv
// One servo output pin: high while the frame counter is below
// the selected pulse width, low when disabled.
module servo_pulse_gen #(
  parameter int CNT_W            = 21,
  parameter int PULSE_FWD_CYCLES = 200_000,
  parameter int PULSE_REV_CYCLES = 100_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt,
  input  logic             enable,
  input  logic             sel_fwd,
  output logic             pin
);

  localparam logic [CNT_W-1:0] FWD_W = CNT_W'(PULSE_FWD_CYCLES);
  localparam logic [CNT_W-1:0] REV_W = CNT_W'(PULSE_REV_CYCLES);

  logic pin_q, pin_d;

  always_comb begin
    pin_d = 1'b0;
    if (enable) begin
      pin_d = sel_fwd ? (cnt < FWD_W) : (cnt < REV_W);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pin_q <= 1'b0;
    else        pin_q <= pin_d;
  end

  assign pin = pin_q;

endmodule

// File: rtl/motor_signal_stream.sv
// Rover drive sequencer: turn in place for A units, then drive
// forward D units, emitting servo frames on both wheel pins.
module motor_signal_stream
  import motor_signal_stream_pkg::*;
#(
  parameter int FRAME_CYCLES     = DEF_FRAME_CYCLES,
  parameter int PULSE_FWD_CYCLES = DEF_PULSE_FWD_CYCLES,
  parameter int PULSE_REV_CYCLES = DEF_PULSE_REV_CYCLES,
  parameter int TURN_FRAMES      = DEF_TURN_FRAMES,
  parameter int MOVE_FRAMES      = DEF_MOVE_FRAMES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        command_ready,
  input  logic [11:0] command,
  output logic        motor_l,
  output logic        motor_r
);

  localparam int CNT_W = $clog2(FRAME_CYCLES);
  localparam int DUR_MAX =
    max_i(31 * TURN_FRAMES, 127 * MOVE_FRAMES);
  localparam int DUR_W = $clog2(DUR_MAX + 1);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [DUR_W-1:0] TF_W = DUR_W'(TURN_FRAMES);
  localparam logic [DUR_W-1:0] MF_W = DUR_W'(MOVE_FRAMES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DUR_W-1:0] frm_q, frm_d;
  logic [4:0]       angle_q, angle_d;
  logic [6:0]       dist_q, dist_d;
  logic             rdy_q;

  logic [4:0]       cmd_a;
  logic [6:0]       cmd_dist;
  logic             accept;
  logic             frame_end;
  logic [DUR_W-1:0] len;

  assign cmd_a     = command[ANGLE_MSB:ANGLE_LSB];
  assign cmd_dist  = command[DIST_MSB:DIST_LSB];
  assign accept    = command_ready && !rdy_q && (state_q == IDLE);
  assign frame_end = (cnt_q == LAST);
  assign len = (state_q == TURN)
             ? DUR_W'(angle_q) * TF_W
             : DUR_W'(dist_q) * MF_W;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frm_d   = frm_q;
    angle_d = angle_q;
    dist_d  = dist_q;
    unique case (state_q)
      TURN, MOVE: begin
        cnt_d = frame_end ? '0 : cnt_q + 1'b1;
        if (frame_end) begin
          if (frm_q == len - 1'b1) begin
            frm_d = '0;
            // Straight move follows a turn seamlessly
            state_d = (state_q == TURN && dist_q != '0)
                    ? MOVE : IDLE;
          end else begin
            frm_d = frm_q + 1'b1;
          end
        end
      end
      default: begin
        cnt_d = '0;
        frm_d = '0;
        if (accept) begin
          angle_d = cmd_a;
          dist_d  = cmd_dist;
          if (cmd_a != '0)         state_d = TURN;
          else if (cmd_dist != '0) state_d = MOVE;
          else                     state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frm_q   <= '0;
      angle_q <= '0;
      dist_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frm_q   <= frm_d;
      angle_q <= angle_d;
      dist_q  <= dist_d;
      rdy_q   <= command_ready;
    end
  end

  logic run;
  logic r_fwd;
  assign run   = (state_q != IDLE);
  assign r_fwd = (state_q == TURN);

  servo_pulse_gen #(
    .CNT_W           (CNT_W),
    .PULSE_FWD_CYCLES(PULSE_FWD_CYCLES),
    .PULSE_REV_CYCLES(PULSE_REV_CYCLES)
  ) u_left (
    .clk    (clock),
    .rst_n  (reset),
    .cnt    (cnt_q),
    .enable (run),
    .sel_fwd(1'b1),
    .pin    (motor_l)
  );

  // Right wheel is mirror-mounted: fwd pulse spins it backward
  servo_pulse_gen #(
    .CNT_W           (CNT_W),
    .PULSE_FWD_CYCLES(PULSE_FWD_CYCLES),
    .PULSE_REV_CYCLES(PULSE_REV_CYCLES)
  ) u_right (
    .clk    (clock),
    .rst_n  (reset),
    .cnt    (cnt_q),
    .enable (run),
    .sel_fwd(r_fwd),
    .pin    (motor_r)
  );

endmodule

// File: tb/tb_motor_signal_stream.sv
// Scoreboard bench: expected pulses (start cycle, width) are queued
// at command issue; a monitor measures pulses and compares.
module tb_motor_signal_stream;

  logic        clock = 1'b0;
  logic        reset;
  logic        command_ready;
  logic [11:0] command;
  logic        motor_l;
  logic        motor_r;

  always #5 clock = ~clock;

  motor_signal_stream #(
    .FRAME_CYCLES    (100),
    .PULSE_FWD_CYCLES(20),
    .PULSE_REV_CYCLES(10),
    .TURN_FRAMES     (2),
    .MOVE_FRAMES     (1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .command_ready(command_ready),
    .command      (command),
    .motor_l      (motor_l),
    .motor_r      (motor_r)
  );

  typedef struct {
    int start;
    int width;
  } exp_t;

  exp_t ql[$];
  exp_t qr[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic pulse_done(input int m, input int s, input int w);
    exp_t e;
    bit   have;
    have = 0;
    checks++;
    if (m == 0) begin
      if (ql.size() > 0) begin e = ql.pop_front(); have = 1; end
    end else begin
      if (qr.size() > 0) begin e = qr.pop_front(); have = 1; end
    end
    if (!have) begin
      errors++;
      $display("FAIL unexpected_pulse motor%0d start=%0d width=%0d required no pulse",
               m, s, w);
    end else if (e.start != s || e.width != w) begin
      errors++;
      $display("FAIL pulse motor%0d got start=%0d width=%0d required start=%0d width=%0d",
               m, s, w, e.start, e.width);
    end
  endtask

  logic prev_l = 1'b0, prev_r = 1'b0;
  int   st_l, st_r, len_l, len_r;

  always @(negedge clock) begin
    if (motor_l) begin
      if (!prev_l) begin st_l = cyc; len_l = 0; end
      len_l++;
    end else if (prev_l) begin
      pulse_done(0, st_l, len_l);
    end
    prev_l = motor_l;
    if (motor_r) begin
      if (!prev_r) begin st_r = cyc; len_r = 0; end
      len_r++;
    end else if (prev_r) begin
      pulse_done(1, st_r, len_r);
    end
    prev_r = motor_r;
  end

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic push_exp(input int c0, input int tf, input int mf);
    for (int k = 0; k < tf + mf; k++) begin
      ql.push_back('{c0 + 1 + 100 * k, 20});
      qr.push_back('{c0 + 1 + 100 * k, (k < tf) ? 20 : 10});
    end
  endtask

  task automatic issue(input logic [11:0] cmd, input int tf,
                       input int mf, output int c0);
    @(negedge clock);
    command       = cmd;
    command_ready = 1'b1;
    c0            = cyc + 1;
    push_exp(c0, tf, mf);
  endtask

  task automatic drop_ready();
    @(negedge clock);
    command_ready = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_done(input string name, input int frames);
    repeat (frames * 100 + 10) @(negedge clock);
    check({name, "_l_left"}, ql.size(), 0);
    check({name, "_r_left"}, qr.size(), 0);
    check({name, "_l_idle"}, int'(motor_l), 0);
    check({name, "_r_idle"}, int'(motor_r), 0);
  endtask

  task automatic cut_queue(input int s);
    exp_t e;
    while (ql.size() > 0 && ql[$].start > s) void'(ql.pop_back());
    while (qr.size() > 0 && qr[$].start > s) void'(qr.pop_back());
    if (ql.size() > 0) begin e = ql.pop_back(); e.width = 5; ql.push_back(e); end
    if (qr.size() > 0) begin e = qr.pop_back(); e.width = 5; qr.push_back(e); end
  endtask

  initial begin
    int c0;
    int s;
    reset         = 1'b0;
    command_ready = 1'b1;
    command       = 12'h004;
    repeat (3) @(negedge clock);
    check("reset_l", int'(motor_l), 0);
    check("reset_r", int'(motor_r), 0);

    // ready already high at reset release is a rising edge
    reset = 1'b1;
    c0    = cyc + 1;
    push_exp(c0, 0, 4);
    wait_done("rel_004", 4);

    repeat (300) @(negedge clock);
    check("held_high_l", ql.size(), 0);
    drop_ready();

    issue(12'h104, 4, 4, c0);
    repeat (150) @(negedge clock);
    command_ready = 1'b0;
    repeat (2) @(negedge clock);
    command       = 12'h081;
    command_ready = 1'b1;
    wait_done("ignore_081", 7);
    repeat (300) @(negedge clock);
    check("held_after_104", ql.size(), 0);

    drop_ready();
    issue(12'h104, 4, 4, c0);
    wait_done("rerun_104", 8);

    drop_ready();
    issue(12'h100, 4, 0, c0);
    wait_done("turn_only", 4);

    drop_ready();
    issue(12'h000, 0, 0, c0);
    wait_done("zero_cmd", 3);

    drop_ready();
    issue(12'h104, 4, 4, c0);
    s = c0 + 501;
    repeat (506) @(negedge clock);
    @(posedge clock);
    #2;
    reset         = 1'b0;
    command_ready = 1'b0;
    cut_queue(s);
    #1;
    check("async_rst_l", int'(motor_l), 0);
    check("async_rst_r", int'(motor_r), 0);
    repeat (3) @(negedge clock);
    check("hold_rst_l", int'(motor_l), 0);
    check("hold_rst_r", int'(motor_r), 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("post_rst_l", int'(motor_l), 0);

    issue(12'h004, 0, 4, c0);
    wait_done("after_rst_004", 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
